dmem_arbiter: RTL

//   Shares the single-port data memory between two requesters: M0 = core load/store path
//   (after the data aligner) and M1 = loader/debug port that preloads or inspects data memory.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_burst_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner ids and the read strobe.
// Pure declarations; no logic or timing of its own.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic       OWNER_M0  = 1'b0;
    localparam logic       OWNER_M1  = 1'b1;
    localparam logic [3:0] WSTB_READ = 4'b0000;

endpackage

// File: rtl/dmem_arbiter_burst_counter.sv
// Counts consecutive grants to the current owner; loads 1 on owner change, saturates at MAX_BURST.
// Updates one cycle after load/inc; no flow control.
module dmem_arbiter_burst_counter #(
    parameter int MAX_BURST = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               i_load,
    input  logic                               i_inc,
    output logic [$clog2(MAX_BURST + 1)-1:0]   o_cnt
);

    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(1);
        end else if (i_inc && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one data memory between core (M0) and loader (M1).
// Grant is same-cycle; read data returns one cycle later on the issuing port; an ungranted REQ simply waits.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
    parameter int          MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        M0_REQ,
    input  logic [29:0] M0_ADDR,
    input  logic [3:0]  M0_WSTB,
    input  logic [31:0] M0_WDATA,
    output logic        M0_GNT,
    output logic        M0_RVALID,
    output logic [31:0] M0_RDATA,
    input  logic        M1_REQ,
    input  logic [29:0] M1_ADDR,
    input  logic [3:0]  M1_WSTB,
    input  logic [31:0] M1_WDATA,
    output logic        M1_GNT,
    output logic        M1_RVALID,
    output logic [31:0] M1_RDATA,
    output logic        MEM_CE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTB,
    output logic [31:0] MEM_DATAO,
    input  logic [31:0] MEM_DATAI
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_BURST);
    localparam logic [11:0]   BASE_HI = DMEM_BASE[31:20];

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          r_last_owner;
    logic [CW-1:0] w_cnt;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_load;
    logic          w_inc;

    logic [29:0]   w_addr;
    logic [3:0]    w_wstb;
    logic [31:0]   w_wdata;
    logic          w_in_range;
    logic          w_is_read;

    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic          r_rd_oor;
    logic [31:0]   w_rdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= OWNER_M1;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0) begin
                r_last_owner <= OWNER_M0;
            end else if (w_gnt1) begin
                r_last_owner <= OWNER_M1;
            end
        end
    end

    // An owner at its burst limit yields only if the other side is actually waiting.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = ARB_IDLE;
        case (r_state)
            ARB_OWN0: begin
                if (M0_REQ && ((w_cnt < MAX_C) || !M1_REQ)) begin
                    w_gnt0 = 1'b1;
                end else if (M1_REQ) begin
                    w_gnt1 = 1'b1;
                end
            end
            ARB_OWN1: begin
                if (M1_REQ && ((w_cnt < MAX_C) || !M0_REQ)) begin
                    w_gnt1 = 1'b1;
                end else if (M0_REQ) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                if (M0_REQ && M1_REQ) begin
                    w_gnt0 = (r_last_owner == OWNER_M1);
                    w_gnt1 = (r_last_owner == OWNER_M0);
                end else begin
                    w_gnt0 = M0_REQ;
                    w_gnt1 = M1_REQ;
                end
            end
        endcase
        if (w_gnt0) begin
            w_state_nxt = ARB_OWN0;
        end else if (w_gnt1) begin
            w_state_nxt = ARB_OWN1;
        end
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_load    = (w_gnt0 && (r_state != ARB_OWN0)) || (w_gnt1 && (r_state != ARB_OWN1));
    assign w_inc     = w_gnt_any && !w_load;

    dmem_arbiter_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_load),
        .i_inc  (w_inc),
        .o_cnt  (w_cnt)
    );

    assign w_addr     = w_gnt1 ? M1_ADDR  : (w_gnt0 ? M0_ADDR  : '0);
    assign w_wstb     = w_gnt1 ? M1_WSTB  : (w_gnt0 ? M0_WSTB  : '0);
    assign w_wdata    = w_gnt1 ? M1_WDATA : (w_gnt0 ? M0_WDATA : '0);
    assign w_in_range = (w_addr[29:18] == BASE_HI);
    assign w_is_read  = (w_wstb == WSTB_READ);

    assign M0_GNT    = w_gnt0;
    assign M1_GNT    = w_gnt1;
    assign MEM_CE    = w_gnt_any && w_in_range;
    assign MEM_ADDR  = w_addr;
    // Strobes are masked so an out-of-range write can never touch memory.
    assign MEM_WSTB  = MEM_CE ? w_wstb : '0;
    assign MEM_DATAO = w_wdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_rd_oor    <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0 && w_is_read;
            r_m1_rvalid <= w_gnt1 && w_is_read;
            r_rd_oor    <= !w_in_range;
        end
    end

    assign w_rdata   = r_rd_oor ? '0 : MEM_DATAI;
    assign M0_RVALID = r_m0_rvalid;
    assign M1_RVALID = r_m1_rvalid;
    assign M0_RDATA  = r_m0_rvalid ? w_rdata : '0;
    assign M1_RDATA  = r_m1_rvalid ? w_rdata : '0;

endmodule
